// File: rtl/alu_pkg.sv
// Shared definitions for the 20-bit ALU sequencer: opcodes, flag indices, FSM encoding.
package alu_pkg;

  localparam int ALU_WIDTH = 20;
  localparam int ALU_HALF  = 10;
  localparam int ALU_CNT_W = 5;

  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_NOT = 5'h01;
  localparam logic [4:0] OP_AND = 5'h02;
  localparam logic [4:0] OP_OR  = 5'h03;
  localparam logic [4:0] OP_XOR = 5'h04;
  localparam logic [4:0] OP_SHR = 5'h05;
  localparam logic [4:0] OP_SHL = 5'h06;
  localparam logic [4:0] OP_ROR = 5'h07;
  localparam logic [4:0] OP_ROL = 5'h08;
  localparam logic [4:0] OP_SWP = 5'h09;
  localparam logic [4:0] OP_INC = 5'h0A;
  localparam logic [4:0] OP_SUB = 5'h0B;
  localparam logic [4:0] OP_EQ  = 5'h0C;
  localparam logic [4:0] OP_LT  = 5'h0D;
  localparam logic [4:0] OP_LDS = 5'h0E;
  localparam logic [4:0] OP_XRS = 5'h0F;

  localparam int FLG_Z = 0;
  localparam int FLG_S = 1;
  localparam int FLG_C = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Shifts and rotates are the only ops that iterate over several cycles.
  function automatic logic op_is_iter(input logic [4:0] op);
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) || (op == OP_ROL);
  endfunction

  function automatic logic op_is_defined(input logic [4:0] op);
    return op <= OP_XRS;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request/response handshake bundle between the CPU control path and the ALU sequencer.
interface alu_seq_ctrl_if #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH,
  parameter int CNT_W = alu_pkg::ALU_CNT_W
);
  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_op;
  logic             req_mode;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [CNT_W-1:0] req_cnt;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_c;
  logic [WIDTH-1:0] rsp_d;

  modport master (
    output req_valid, req_op, req_mode, req_a, req_b, req_cnt, rsp_ready,
    input  req_ready, rsp_valid, rsp_c, rsp_d
  );

  modport slave (
    input  req_valid, req_op, req_mode, req_a, req_b, req_cnt, rsp_ready,
    output req_ready, rsp_valid, rsp_c, rsp_d
  );
endinterface

// File: rtl/alu_step_unit.sv
// Combinational single ALU step: one bit of shift/rotate, or a complete simple op.
// Results are confined to the active width; undefined opcodes behave as NOP.
module alu_step_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int HALF  = ALU_HALF
) (
  input  logic [4:0]       op_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       status_i,
  output logic [WIDTH-1:0] y_o,
  output logic [WIDTH-1:0] y2_o,
  output logic [2:0]       flags_next_o,
  output logic [2:0]       flag_we_o
);

  localparam int IW = $clog2(WIDTH);

  logic [WIDTH-1:0] mask;
  logic [IW-1:0]    msb;
  logic [WIDTH:0]   sum;

  always_comb begin
    mask = '0;
    mask[HALF-1:0] = '1;
    if (mode_i) mask = '1;
    msb = mode_i ? IW'(WIDTH - 1) : IW'(HALF - 1);
    sum = {1'b0, x_i} + {{WIDTH{1'b0}}, 1'b1};

    y_o          = '0;
    y2_o         = '0;
    flags_next_o = status_i;
    flag_we_o    = 3'b000;

    case (op_i)
      OP_NOT, OP_AND, OP_OR, OP_XOR: begin
        case (op_i)
          OP_NOT:  y_o = ~x_i & mask;
          OP_AND:  y_o = x_i & b_i;
          OP_OR:   y_o = x_i | b_i;
          default: y_o = x_i ^ b_i;
        endcase
        flags_next_o[FLG_Z] = ~|y_o;
        flags_next_o[FLG_S] = y_o[msb];
        flag_we_o = 3'b011;
      end
      OP_SHR: begin
        y_o = (x_i << 1) & mask;
        flags_next_o[FLG_C] = x_i[msb];
        flags_next_o[FLG_Z] = ~|y_o;
        flag_we_o = 3'b101;
      end
      OP_SHL: begin
        y_o = x_i >> 1;
        flags_next_o[FLG_C] = x_i[0];
        flags_next_o[FLG_Z] = ~|y_o;
        flag_we_o = 3'b101;
      end
      OP_ROR: begin
        y_o = ((x_i << 1) | {{(WIDTH-1){1'b0}}, x_i[msb]}) & mask;
        flags_next_o[FLG_Z] = ~|y_o;
        flag_we_o = 3'b001;
      end
      OP_ROL: begin
        y_o = x_i >> 1;
        y_o[msb] = x_i[0];
        flags_next_o[FLG_Z] = ~|y_o;
        flag_we_o = 3'b001;
      end
      OP_SWP: begin
        y_o  = b_i;
        y2_o = x_i;
      end
      OP_INC: begin
        // Carry out of the active width; x_i is already masked, so the bit above is clean.
        y_o = sum[WIDTH-1:0] & mask;
        flags_next_o[FLG_C] = mode_i ? sum[WIDTH] : sum[HALF];
        flags_next_o[FLG_Z] = ~|y_o;
        flag_we_o = 3'b101;
      end
      OP_SUB: begin
        y_o = (x_i - b_i) & mask;
        flags_next_o[FLG_C] = x_i < b_i;
        flags_next_o[FLG_S] = y_o[msb];
        flags_next_o[FLG_Z] = ~|y_o;
        flag_we_o = 3'b111;
      end
      OP_EQ: begin
        flags_next_o[FLG_Z] = x_i == b_i;
        flag_we_o = 3'b001;
      end
      OP_LT: begin
        flags_next_o[FLG_S] = x_i < b_i;
        flag_we_o = 3'b010;
      end
      OP_LDS: begin
        flags_next_o = x_i[2:0];
        flag_we_o    = 3'b111;
        y_o          = WIDTH'(x_i[2:0]);
      end
      OP_XRS: begin
        flags_next_o = status_i ^ x_i[2:0];
        flag_we_o    = 3'b111;
        y_o          = WIDTH'(status_i ^ x_i[2:0]);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// ALU sequencer: IDLE/EXEC/RESP FSM, response after max(1,cnt) cycles, held until rsp_ready.
// Optional ALU_TRAP_EN adds a sticky trap output for undefined opcodes that blocks new requests.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int HALF  = ALU_HALF,
  parameter int CNT_W = ALU_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  alu_seq_ctrl_if.slave    bus,
  output logic [2:0]       status,
  output logic             busy
`ifdef ALU_TRAP_EN
  ,
  output logic             trap
`endif
);

  state_e           state_q;
  logic [4:0]       op_q;
  logic             mode_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] b_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rsp_c_q;
  logic [WIDTH-1:0] rsp_d_q;
  logic [2:0]       status_q;
  logic             rsp_valid_q;
  logic             req_ready_q;
  logic             busy_q;
  logic             trap_q;

  logic [WIDTH-1:0] in_mask;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       status_d;
  logic [WIDTH-1:0] step_y;
  logic [WIDTH-1:0] step_y2;
  logic [2:0]       step_flags;
  logic [2:0]       step_we;

  alu_step_unit #(
    .WIDTH (WIDTH),
    .HALF  (HALF)
  ) u_step (
    .op_i         (op_q),
    .mode_i       (mode_q),
    .x_i          (work_q),
    .b_i          (b_q),
    .status_i     (status_q),
    .y_o          (step_y),
    .y2_o         (step_y2),
    .flags_next_o (step_flags),
    .flag_we_o    (step_we)
  );

  always_comb begin
    in_mask = '0;
    in_mask[HALF-1:0] = '1;
    if (bus.req_mode) in_mask = '1;
    // Non-iterating ops and cnt of 0 or 1 all run a single step.
    cnt_d = (op_is_iter(bus.req_op) && (bus.req_cnt > CNT_W'(1))) ? bus.req_cnt : CNT_W'(1);
    status_d = (status_q & ~step_we) | (step_flags & step_we);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NOP;
      mode_q      <= 1'b0;
      work_q      <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      rsp_c_q     <= '0;
      rsp_d_q     <= '0;
      status_q    <= 3'b000;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      trap_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            op_q        <= bus.req_op;
            mode_q      <= bus.req_mode;
            work_q      <= bus.req_a & in_mask;
            b_q         <= bus.req_b & in_mask;
            cnt_q       <= cnt_d;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_q <= CNT_W'(1)) begin
            rsp_c_q     <= step_y;
            rsp_d_q     <= step_y2;
            status_q    <= status_d;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
`ifdef ALU_TRAP_EN
            if (!op_is_defined(op_q)) trap_q <= 1'b1;
`endif
          end else begin
            work_q <= step_y;
            cnt_q  <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= ~trap_q;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_c     = rsp_c_q;
  assign bus.rsp_d     = rsp_d_q;
  assign status        = status_q;
  assign busy          = busy_q;
`ifdef ALU_TRAP_EN
  assign trap          = trap_q;
`else
  logic unused_trap;
  assign unused_trap = trap_q;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: expected responses queued at issue, compared on rsp_valid.
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  typedef struct {
    logic [19:0] c;
    logic [19:0] d;
    logic [2:0]  st;
    int          lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] status;
  logic       busy;
`ifdef ALU_TRAP_EN
  logic       trap;
`endif

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  alu_seq_ctrl_if #(.WIDTH(20), .CNT_W(5)) bus ();

  alu_seq_ctrl #(.WIDTH(20), .HALF(10), .CNT_W(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .status (status),
    .busy   (busy)
`ifdef ALU_TRAP_EN
    ,
    .trap   (trap)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic mode,
                        input logic [19:0] a, input logic [19:0] b, input logic [4:0] cnt,
                        input logic [19:0] ec, input logic [19:0] ed, input logic [2:0] es,
                        input int lat, input int hold);
    exp_t e;
    exp_t got;
    int   n;
    e.c = ec; e.d = ed; e.st = es; e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_mode = mode;
    bus.req_a = a; bus.req_b = b; bus.req_cnt = cnt;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    check({tag, "_accept"}, bus.req_ready, 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check({tag, "_busy"}, busy, 1);
    n = 0;
    while (!bus.rsp_valid && n < 64) begin @(negedge clk); n++; end
    check({tag, "_lat"}, n, e.lat);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check({tag, "_c"}, bus.rsp_c, got.c);
      check({tag, "_d"}, bus.rsp_d, got.d);
      check({tag, "_st"}, status, got.st);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, "_hold_vld"}, bus.rsp_valid, 1);
        check({tag, "_hold_c"}, bus.rsp_c, got.c);
      end
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({tag, "_done_vld"}, bus.rsp_valid, 0);
    check({tag, "_done_busy"}, busy, 0);
  endtask

  initial begin
    int seen;
    bus.req_valid = 1'b0; bus.req_op = OP_NOP; bus.req_mode = 1'b0;
    bus.req_a = '0; bus.req_b = '0; bus.req_cnt = '0; bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", bus.req_ready, 1);
    check("rst_vld", bus.rsp_valid, 0);
    check("rst_c", bus.rsp_c, 0);
    check("rst_d", bus.rsp_d, 0);
    check("rst_st", status, 0);
    check("rst_busy", busy, 0);

    // Make status nonzero so the mid-operation reset has something to clear.
    run_op("lds_pre", OP_LDS, 1'b1, 20'h00005, 20'h0, 5'd0, 20'h00005, 20'h0, 3'b101, 1, 0);

    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = OP_ROR; bus.req_mode = 1'b1;
    bus.req_a = 20'h00001; bus.req_b = '0; bus.req_cnt = 5'd10;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", bus.req_ready, 1);
    check("midrst_vld", bus.rsp_valid, 0);
    check("midrst_st", status, 0);
    check("midrst_busy", busy, 0);
    seen = 0;
    repeat (15) begin @(negedge clk); if (bus.rsp_valid) seen++; end
    check("midrst_no_rsp", seen, 0);

    run_op("lds_c",  OP_LDS, 1'b1, 20'h00004, 20'h0,     5'd0, 20'h00004, 20'h0, 3'b100, 1, 0);
    run_op("and",    OP_AND, 1'b1, 20'hF0F0F, 20'h0FF00, 5'd0, 20'h00F00, 20'h0, 3'b100, 1, 0);
    run_op("shl2",   OP_SHL, 1'b1, 20'h00003, 20'h0,     5'd2, 20'h00000, 20'h0, 3'b101, 2, 0);
    run_op("inc_h",  OP_INC, 1'b0, 20'h003FF, 20'h0,     5'd0, 20'h00000, 20'h0, 3'b101, 1, 0);
    run_op("sub",    OP_SUB, 1'b1, 20'h00005, 20'h00007, 5'd0, 20'hFFFFE, 20'h0, 3'b110, 1, 3);
    run_op("lds",    OP_LDS, 1'b1, 20'h00005, 20'h0,     5'd0, 20'h00005, 20'h0, 3'b101, 1, 0);
    run_op("xrs",    OP_XRS, 1'b1, 20'h00007, 20'h0,     5'd0, 20'h00002, 20'h0, 3'b010, 1, 0);
    run_op("swp",    OP_SWP, 1'b1, 20'h12345, 20'hABCDE, 5'd0, 20'hABCDE, 20'h12345, 3'b010, 1, 0);
    run_op("shr3_h", OP_SHR, 1'b0, 20'hFFE01, 20'h0,     5'd3, 20'h00008, 20'h0, 3'b010, 3, 0);
    run_op("rol0",   OP_ROL, 1'b1, 20'h00001, 20'h0,     5'd0, 20'h80000, 20'h0, 3'b010, 1, 0);
    run_op("ror1_h", OP_ROR, 1'b0, 20'h00200, 20'h0,     5'd1, 20'h00001, 20'h0, 3'b010, 1, 0);
    run_op("eq",     OP_EQ,  1'b1, 20'h00007, 20'h00007, 5'd7, 20'h00000, 20'h0, 3'b011, 1, 0);
    run_op("lt_h",   OP_LT,  1'b0, 20'h00009, 20'h00003, 5'd0, 20'h00000, 20'h0, 3'b001, 1, 0);
    run_op("or_h",   OP_OR,  1'b0, 20'hFFFFF, 20'h00000, 5'd0, 20'h003FF, 20'h0, 3'b010, 1, 0);
    run_op("not",    OP_NOT, 1'b1, 20'hFFFFF, 20'h0,     5'd0, 20'h00000, 20'h0, 3'b001, 1, 0);
    run_op("nop",    OP_NOP, 1'b1, 20'h00123, 20'h0,     5'd0, 20'h00000, 20'h0, 3'b001, 1, 0);
    run_op("undef",  5'h1F,  1'b1, 20'h00123, 20'h0,     5'd0, 20'h00000, 20'h0, 3'b001, 1, 0);

    @(negedge clk);
`ifdef ALU_TRAP_EN
    check("trap_set", trap, 1);
    check("trap_ready", bus.req_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("trap_clr", trap, 0);
    check("trap_clr_ready", bus.req_ready, 1);
`else
    check("undef_ready", bus.req_ready, 1);
`endif
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
